// File: rtl/seq_frame_pkg.sv
// seq_frame_pkg
// Definitions shared by the frame transmitter and the "1001" detector path:
// the transmitter state encoding, the default marker definition and frame
// geometry, and a helper that sizes the position counter.
package seq_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } tx_state_t;

    // One marker definition for both the detector and the transmitter.
    localparam int                    DEF_SYNC_W   = 4;
    localparam logic [DEF_SYNC_W-1:0] DEF_SYNC_PAT = 4'b1001;
    localparam int                    DEF_DATA_W   = 8;
    localparam int                    DEF_GAP_BITS = 2;

    // The counter runs 0..N-1 inside the longest phase. It is never narrower
    // than one bit, even when every phase is a single bit long.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/seq_frame_tx_if.sv
// seq_frame_tx_if
// Producer-side handshake and serial output bundle of seq_frame_tx.
//   load       : producer valid, taken only while ready is high
//   data_in    : payload word, captured on the accepting edge
//   ready      : transmitter idle and able to accept a word
//   dout       : registered serial bit, feeds the detector's din
//   busy       : a frame is currently on dout
//   frame_done : one-cycle pulse on returning to idle after a frame
// master = producer/observer side, slave = transmitter side.
interface seq_frame_tx_if #(
    parameter int DATA_W = seq_frame_pkg::DEF_DATA_W
);
    logic              load;
    logic [DATA_W-1:0] data_in;
    logic              ready;
    logic              dout;
    logic              busy;
    logic              frame_done;

    modport master (
        output load, data_in,
        input  ready, dout, busy, frame_done
    );

    modport slave (
        input  load, data_in,
        output ready, dout, busy, frame_done
    );
endinterface

// File: rtl/seq_frame_tx_piso_shift.sv
// piso_shift
// Parallel-load, MSB-first shift register. The serial output is the MSB
// register itself, so it carries no combinational path from any input.
//   clk    : clock, rising edge
//   reset  : synchronous active-high clear
//   load   : capture par_in (has priority over shift)
//   shift  : move one place towards the MSB, zero filled from the LSB
//   par_in : parallel word
//   msb    : current most-significant bit
module piso_shift #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] par_in,
    output logic             msb
);

    logic [WIDTH-1:0] sr_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_reg <= '0;
        end else if (load) begin
            sr_reg <= par_in;
        end else if (shift) begin
            sr_reg <= {sr_reg[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = sr_reg[WIDTH-1];

endmodule

// File: rtl/seq_frame_tx.sv
// seq_frame_tx
// Serial frame transmitter for the "1001" detector: each accepted word goes
// out as the marker pattern, then the payload MSB first, then GAP_BITS idle
// zeros. One bit per clock.
//   clk   : single clock, rising edge
//   reset : synchronous active-high reset
//   bus   : seq_frame_tx_if.slave (load/data_in in; ready/dout/busy/frame_done out)
module seq_frame_tx
    import seq_frame_pkg::*;
#(
    parameter int                SYNC_W   = DEF_SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_PAT = DEF_SYNC_PAT,
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                GAP_BITS = DEF_GAP_BITS
) (
    input logic           clk,
    input logic           reset,
    seq_frame_tx_if.slave bus
);

    localparam int FRAME_W = SYNC_W + DATA_W;
    localparam int CNT_W   = cnt_width(SYNC_W, DATA_W, GAP_BITS);

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    tx_state_t        state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             ready_reg;
    logic             busy_reg;
    logic             done_reg;

    logic             sr_load;
    logic             sr_shift;
    logic             sr_msb;

    // Marker and payload sit in one register. The accepting edge loads it,
    // so its MSB (the first marker bit) is on dout right after that edge.
    // Every SYNC/DATA cycle advances one bit. After SYNC_W+DATA_W shifts
    // only zero fill is left, which gives the gap and idle level for free.
    assign sr_load  = (state_reg == IDLE) && bus.load;
    assign sr_shift = (state_reg == SYNC) || (state_reg == DATA);

    piso_shift #(
        .WIDTH (FRAME_W)
    ) u_shift (
        .clk    (clk),
        .reset  (reset),
        .load   (sr_load),
        .shift  (sr_shift),
        .par_in ({SYNC_PAT, bus.data_in}),
        .msb    (sr_msb)
    );

    // cnt_reg is the index of the bit on dout within the current phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.load) begin
                        state_reg <= SYNC;
                        cnt_reg   <= '0;
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                    end
                end
                SYNC: begin
                    if (cnt_reg == SYNC_LAST) begin
                        state_reg <= DATA;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_reg == DATA_LAST) begin
                        cnt_reg <= '0;
                        if (GAP_BITS > 0) begin
                            state_reg <= GAP;
                        end else begin
                            state_reg <= IDLE;
                            ready_reg <= 1'b1;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_reg == GAP_LAST) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.dout       = sr_msb;
    assign bus.ready      = ready_reg;
    assign bus.busy       = busy_reg;
    assign bus.frame_done = done_reg;

endmodule
